// File: rtl/pipeline_cache_control_nway_pkg.sv
// Shared types and helpers for the N-way pipeline cache controller.
package pipeline_cache_control_nway_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    ALLOCATE,
    VERIFY,
    FL_READ,
    FL_CHECK,
    FL_WB,
    FL_DONE
  } cache_state_t;

  // Helpers work on a fixed maximum width; callers zero-extend and truncate.
  localparam int MAX_WAYS  = 32;
  localparam int MAX_WAY_W = 5;

  // found sits in the LSB so a caller can size-cast to {idx[WAY_W-1:0], found}.
  typedef struct packed {
    logic [MAX_WAY_W-1:0] idx;
    logic                 found;
  } first_inv_t;

  // Index of the lowest set bit among the first n bits (0 when none set).
  function automatic int lowest_one(input logic [MAX_WAYS-1:0] vec, input int n);
    lowest_one = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (vec[i]) lowest_one = i;
    end
  endfunction

  // Lowest way whose valid bit is clear, among the first n ways.
  function automatic first_inv_t first_invalid(input logic [MAX_WAYS-1:0] valid, input int n);
    logic [MAX_WAYS-1:0] inv;
    inv = '0;
    for (int i = 0; i < n; i++) begin
      inv[i] = ~valid[i];
    end
    first_invalid.found = |inv;
    first_invalid.idx   = MAX_WAY_W'(lowest_one(inv, n));
  endfunction

  function automatic logic [MAX_WAYS-1:0] onehot(input int idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/pipeline_cache_control_nway_if.sv
// CPU pipeline / datapath / pmem signal bundle of the cache controller.
interface pipeline_cache_control_nway_if #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 8
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int SET_W = $clog2(NUM_SETS);

  logic                mem_read;
  logic                mem_write;
  logic                cpu_stall;
  logic                clear;
  logic                flush_req;
  logic [NUM_WAYS-1:0] hit_vec;
  logic [NUM_WAYS-1:0] valid_vec;
  logic [NUM_WAYS-1:0] dirty_vec;
  logic [WAY_W-1:0]    lru_way;
  logic                pmem_resp;

  logic                mem_resp;
  logic                cache_stall;
  logic                pmem_read;
  logic                pmem_write;
  logic                pmem_addr_muxsel;
  logic                use_resp_addr;
  logic                flush_addr_sel;
  logic                array_read;
  logic [NUM_WAYS-1:0] tag_load;
  logic [NUM_WAYS-1:0] valid_load;
  logic [NUM_WAYS-1:0] dirty_load;
  logic                valid_in;
  logic                dirty_in;
  logic                lru_load;
  logic                mbe_sel;
  logic [NUM_WAYS-1:0] mbe_way_sel;
  logic [SET_W-1:0]    flush_set;
  logic [WAY_W-1:0]    flush_way;
  logic                flush_done;

  // Controller side.
  modport slave (
    input  mem_read, mem_write, cpu_stall, clear, flush_req, hit_vec, valid_vec,
           dirty_vec, lru_way, pmem_resp,
    output mem_resp, cache_stall, pmem_read, pmem_write, pmem_addr_muxsel, use_resp_addr,
           flush_addr_sel, array_read, tag_load, valid_load, dirty_load, valid_in, dirty_in,
           lru_load, mbe_sel, mbe_way_sel, flush_set, flush_way, flush_done
  );

  // Pipeline / datapath side.
  modport master (
    output mem_read, mem_write, cpu_stall, clear, flush_req, hit_vec, valid_vec,
           dirty_vec, lru_way, pmem_resp,
    input  mem_resp, cache_stall, pmem_read, pmem_write, pmem_addr_muxsel, use_resp_addr,
           flush_addr_sel, array_read, tag_load, valid_load, dirty_load, valid_in, dirty_in,
           lru_load, mbe_sel, mbe_way_sel, flush_set, flush_way, flush_done
  );
endinterface

// File: rtl/pipeline_cache_control_nway_victim_sel.sv
// Miss victim choice: lowest invalid way if any, otherwise the LRU way.
module pipeline_cache_control_nway_victim_sel
  import pipeline_cache_control_nway_pkg::*;
#(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-1:0]         valid_vec,
  input  logic [$clog2(NUM_WAYS)-1:0] lru_way,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic [WAY_W:0] inv_sel;  // {idx, found}

  // Filling an empty way never costs a writeback, so it beats the LRU way.
  always_comb begin
    inv_sel    = (WAY_W + 1)'(first_invalid(MAX_WAYS'(valid_vec), NUM_WAYS));
    victim_way = inv_sel[0] ? inv_sel[WAY_W:1] : lru_way;
  end
endmodule

// File: rtl/pipeline_cache_control_nway.sv
// Control FSM for an N-way set-associative write-back/write-allocate pipeline cache,
// including a whole-cache flush walk.
module pipeline_cache_control_nway
  import pipeline_cache_control_nway_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 8
) (
  input logic                         clk,
  input logic                         rst,
  pipeline_cache_control_nway_if.slave bus
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int SET_W = $clog2(NUM_SETS);

  cache_state_t        state;
  logic                op_wr_q;
  logic [WAY_W-1:0]    victim_q;
  logic [SET_W-1:0]    fl_set_q;
  logic [WAY_W-1:0]    fl_way_q;

  logic                req;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim_way;
  logic                miss_dirty;
  logic                fl_dirty;
  logic                fl_last;
  logic                fl_adv;
  logic [NUM_WAYS-1:0] hit_oh;
  logic [NUM_WAYS-1:0] victim_oh;
  logic [NUM_WAYS-1:0] fl_oh;

  pipeline_cache_control_nway_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_victim_sel (
    .valid_vec  (bus.valid_vec),
    .lru_way    (bus.lru_way),
    .victim_way (victim_way)
  );

  // Request decode, hit way, and flush-walk bookkeeping.
  always_comb begin
    req        = bus.mem_read | bus.mem_write;
    hit        = |bus.hit_vec;
    hit_way    = WAY_W'(lowest_one(MAX_WAYS'(bus.hit_vec), NUM_WAYS));
    hit_oh     = NUM_WAYS'(onehot(int'(hit_way)));
    victim_oh  = NUM_WAYS'(onehot(int'(victim_q)));
    fl_oh      = NUM_WAYS'(onehot(int'(fl_way_q)));
    miss_dirty = bus.valid_vec[victim_way] & bus.dirty_vec[victim_way];
    fl_dirty   = bus.valid_vec[fl_way_q] & bus.dirty_vec[fl_way_q];
    fl_last    = (fl_way_q == WAY_W'(NUM_WAYS - 1)) && (fl_set_q == SET_W'(NUM_SETS - 1));
    fl_adv     = ((state == FL_CHECK) && !fl_dirty) || ((state == FL_WB) && bus.pmem_resp);
  end

  assign bus.flush_set = fl_set_q;
  assign bus.flush_way = fl_way_q;

  // State, latched op/victim and flush walk counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_wr_q  <= 1'b0;
      victim_q <= '0;
      fl_set_q <= '0;
      fl_way_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            state    <= FL_READ;
            fl_set_q <= '0;
            fl_way_q <= '0;
          end else if (req) begin
            state   <= CHECK;
            op_wr_q <= bus.mem_write & ~bus.mem_read;
          end
        end
        CHECK: begin
          if (bus.clear) begin
            state <= IDLE;
          end else if (hit) begin
            if (!bus.cpu_stall) begin
              if (req) op_wr_q <= bus.mem_write & ~bus.mem_read;
              else     state   <= IDLE;
            end
          end else begin
            victim_q <= victim_way;
            state    <= miss_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (bus.pmem_resp) state <= ALLOCATE;
        ALLOCATE:  if (bus.pmem_resp) state <= VERIFY;
        VERIFY: begin
          if (bus.clear) begin
            state <= IDLE;
          end else if (!bus.cpu_stall && hit) begin
            if (req) begin
              state   <= CHECK;
              op_wr_q <= bus.mem_write & ~bus.mem_read;
            end else begin
              state <= IDLE;
            end
          end
        end
        FL_READ:  state <= FL_CHECK;
        FL_CHECK: if (fl_dirty) state <= FL_WB;
        FL_WB:    ;
        FL_DONE:  state <= IDLE;
        default:  state <= IDLE;
      endcase
      // Step the walk after a clean visit or a completed line writeback.
      if (fl_adv) begin
        if (fl_last) begin
          state <= FL_DONE;
        end else begin
          state    <= FL_READ;
          fl_way_q <= fl_way_q + 1'b1;
          if (fl_way_q == WAY_W'(NUM_WAYS - 1)) fl_set_q <= fl_set_q + 1'b1;
        end
      end
    end
  end

  // Per-state control outputs to the pipeline, arrays and pmem.
  always_comb begin
    bus.mem_resp         = 1'b0;
    bus.cache_stall      = 1'b0;
    bus.pmem_read        = 1'b0;
    bus.pmem_write       = 1'b0;
    bus.pmem_addr_muxsel = 1'b0;
    bus.use_resp_addr    = 1'b0;
    bus.flush_addr_sel   = 1'b0;
    bus.array_read       = 1'b0;
    bus.tag_load         = '0;
    bus.valid_load       = '0;
    bus.dirty_load       = '0;
    bus.valid_in         = 1'b0;
    bus.dirty_in         = 1'b0;
    bus.lru_load         = 1'b0;
    bus.mbe_sel          = 1'b0;
    bus.mbe_way_sel      = '0;
    bus.flush_done       = 1'b0;
    case (state)
      IDLE: bus.array_read = !bus.flush_req && req;
      CHECK, VERIFY: begin
        bus.array_read    = 1'b1;
        bus.lru_load      = hit;
        bus.mem_resp      = hit | bus.clear;
        bus.cache_stall   = !hit | bus.cpu_stall;
        bus.use_resp_addr = (state == CHECK) ? !hit : bus.cpu_stall;
        if (op_wr_q && hit) begin
          bus.mbe_way_sel = hit_oh;
          bus.dirty_load  = hit_oh;
          bus.dirty_in    = 1'b1;
        end
      end
      WRITEBACK: begin
        bus.pmem_write       = 1'b1;
        bus.pmem_addr_muxsel = 1'b1;
        bus.cache_stall      = 1'b1;
        bus.use_resp_addr    = 1'b1;
      end
      ALLOCATE: begin
        bus.pmem_read   = 1'b1;
        bus.cache_stall = 1'b1;
        if (bus.pmem_resp) begin
          // A fill always lands clean; only a CPU write marks a line dirty.
          bus.mbe_sel       = 1'b1;
          bus.mbe_way_sel   = victim_oh;
          bus.tag_load      = victim_oh;
          bus.valid_load    = victim_oh;
          bus.dirty_load    = victim_oh;
          bus.valid_in      = 1'b1;
          bus.array_read    = 1'b1;
          bus.use_resp_addr = 1'b1;
        end
      end
      FL_READ: begin
        bus.cache_stall    = 1'b1;
        bus.flush_addr_sel = 1'b1;
        bus.array_read     = 1'b1;
      end
      FL_CHECK: begin
        bus.cache_stall    = 1'b1;
        bus.flush_addr_sel = 1'b1;
        if (!fl_dirty) bus.valid_load = fl_oh;
      end
      FL_WB: begin
        bus.pmem_write       = 1'b1;
        bus.pmem_addr_muxsel = 1'b1;
        bus.cache_stall      = 1'b1;
        bus.flush_addr_sel   = 1'b1;
        if (bus.pmem_resp) begin
          bus.valid_load = fl_oh;
          bus.dirty_load = fl_oh;
        end
      end
      FL_DONE: bus.flush_done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pipeline_cache_control_nway.sv
// Bench for the N-way cache controller: a 4-way/8-set instance for CPU traffic and a
// 2-way/2-set instance for the flush walk, both driven against a transaction-level model.
module tb_pipeline_cache_control_nway;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_cache_control_nway_if #(.NUM_WAYS(4), .NUM_SETS(8)) b4 ();
  pipeline_cache_control_nway_if #(.NUM_WAYS(2), .NUM_SETS(2)) b2 ();

  pipeline_cache_control_nway #(.NUM_WAYS(4), .NUM_SETS(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  pipeline_cache_control_nway #(.NUM_WAYS(2), .NUM_SETS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  int checks   = 0;
  int failures = 0;
  bit v2 [2][2];
  bit d2 [2][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle4(input string tag);
    chk(tag, 32'({b4.mem_resp, b4.cache_stall, b4.pmem_read, b4.pmem_write, b4.array_read,
                  b4.lru_load, b4.flush_done, b4.tag_load, b4.valid_load, b4.dirty_load,
                  b4.mbe_way_sel}), 0);
  endtask

  // One CPU request on the 4-way instance, from IDLE back to IDLE.
  task automatic txn4(input string nm, input bit wr, input logic [3:0] hv, input logic [3:0] vv,
                      input logic [3:0] dv, input logic [1:0] lru, input int stall, input bit clrv);
    int v;
    int dly;
    bit wb;
    logic st;
    logic [3:0] ov;
    logic [3:0] wexp;
    b4.mem_read  = !wr;
    b4.mem_write = wr;
    b4.hit_vec   = hv;
    b4.valid_vec = vv;
    b4.dirty_vec = dv;
    b4.lru_way   = lru;
    b4.cpu_stall = 1'b0;
    b4.clear     = 1'b0;
    b4.pmem_resp = 1'b0;
    #1 chk({nm, ":req_array_read"}, 32'(b4.array_read), 1);
    step();
    if (hv != 4'b0000) begin
      wexp = wr ? hv : 4'b0000;
      for (int s = 0; s <= stall; s++) begin
        st = (s < stall);
        b4.cpu_stall = st;
        if (!st) begin
          b4.mem_read  = 1'b0;
          b4.mem_write = 1'b0;
        end
        #1;
        chk({nm, ":hit_resp"}, 32'({b4.mem_resp, b4.lru_load, b4.pmem_read, b4.pmem_write,
                                    b4.cache_stall, b4.use_resp_addr}), 32'({4'b1100, st, 1'b0}));
        chk({nm, ":hit_dirty"}, 32'({b4.dirty_load, b4.mbe_way_sel, b4.dirty_in}),
            32'({wexp, wexp, wr}));
        step();
      end
    end else begin
      v = 4;
      for (int i = 3; i >= 0; i--) if (!vv[i]) v = i;
      if (v == 4) v = int'(lru);
      ov = 4'b0001 << v;
      wb = vv[v] & dv[v];
      #1 chk({nm, ":miss"}, 32'({b4.mem_resp, b4.cache_stall, b4.use_resp_addr, b4.lru_load,
                                 b4.pmem_read, b4.pmem_write}), 32'(6'b011000));
      step();
      if (wb) begin
        dly = $urandom_range(0, 3);
        #1 chk({nm, ":wb"}, 32'({b4.pmem_write, b4.pmem_addr_muxsel, b4.pmem_read,
                                 b4.cache_stall, b4.use_resp_addr}), 32'(5'b11011));
        repeat (dly) step();
        b4.pmem_resp = 1'b1;
        #1 chk({nm, ":wb_resp"}, 32'(b4.pmem_write), 1);
        step();
        b4.pmem_resp = 1'b0;
      end
      dly = $urandom_range(0, 3);
      #1 chk({nm, ":alloc"}, 32'({b4.pmem_read, b4.pmem_write, b4.pmem_addr_muxsel,
                                  b4.cache_stall, b4.tag_load}), 32'({4'b1001, 4'b0000}));
      repeat (dly) step();
      b4.pmem_resp = 1'b1;
      #1 chk({nm, ":fill_loads"}, 32'({b4.tag_load, b4.valid_load, b4.dirty_load, b4.mbe_way_sel}),
             32'({ov, ov, ov, ov}));
      chk({nm, ":fill_ctl"}, 32'({b4.mbe_sel, b4.valid_in, b4.dirty_in, b4.array_read,
                                  b4.use_resp_addr}), 32'(5'b11011));
      step();
      b4.pmem_resp = 1'b0;
      if (clrv) begin
        b4.clear     = 1'b1;
        b4.cpu_stall = 1'b1;
        b4.hit_vec   = 4'b0000;
        #1 chk({nm, ":verify_clear"}, 32'({b4.mem_resp, b4.cache_stall}), 32'(2'b11));
      end else begin
        b4.hit_vec   = ov;
        b4.mem_read  = 1'b0;
        b4.mem_write = 1'b0;
        wexp = wr ? ov : 4'b0000;
        #1 chk({nm, ":verify"}, 32'({b4.mem_resp, b4.cache_stall, b4.pmem_read,
                                     b4.use_resp_addr, b4.lru_load}), 32'(5'b10001));
        chk({nm, ":verify_dirty"}, 32'({b4.dirty_load, b4.dirty_in}), 32'({wexp, wr}));
      end
      b4.mem_read  = 1'b0;
      b4.mem_write = 1'b0;
      step();
    end
    b4.hit_vec   = 4'b0000;
    b4.cpu_stall = 1'b0;
    b4.clear     = 1'b0;
    #1 idle4({nm, ":back_idle"});
  endtask

  // Whole-cache flush of the 2-way/2-set instance; v2/d2 act as its valid/dirty arrays.
  task automatic run_flush2(input string nm);
    int exp_wb;
    int wbs;
    int visits;
    int dones;
    int age;
    int ls;
    int lw;
    bit done;
    logic [1:0] vl;
    logic [1:0] dl;
    logic vin;
    logic din;
    exp_wb = 0;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 2; w++) if (v2[s][w] && d2[s][w]) exp_wb++;
    wbs = 0; visits = 0; dones = 0; age = 0; done = 1'b0;
    b2.flush_req = 1'b1;
    b2.mem_read  = 1'b1;
    #1 chk({nm, ":flush_priority"}, 32'({b2.array_read, b2.cache_stall}), 0);
    step();
    b2.flush_req = 1'b0;
    b2.mem_read  = 1'b0;
    chk({nm, ":walk_start"}, 32'({b2.flush_set, b2.flush_way}), 0);
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      ls = int'(b2.flush_set);
      lw = int'(b2.flush_way);
      b2.valid_vec = {v2[ls][1], v2[ls][0]};
      b2.dirty_vec = {d2[ls][1], d2[ls][0]};
      b2.pmem_resp = 1'b0;
      b2.clear     = 1'($urandom_range(0, 1));
      #1;
      if (b2.pmem_write) begin
        if (age >= 1) begin
          chk({nm, ":wb_line"}, 32'({b2.pmem_addr_muxsel, v2[ls][lw], d2[ls][lw]}), 32'(3'b111));
          b2.pmem_resp = 1'b1;
          #1;
          wbs++;
          age = 0;
        end else begin
          age++;
        end
      end
      if (b2.flush_addr_sel && b2.array_read) visits++;
      if (b2.flush_done) begin
        dones++;
        done = 1'b1;
      end
      vl  = b2.valid_load;
      dl  = b2.dirty_load;
      vin = b2.valid_in;
      din = b2.dirty_in;
      step();
      for (int w = 0; w < 2; w++) begin
        if (vl[w]) v2[ls][w] = vin;
        if (dl[w]) d2[ls][w] = din;
      end
    end
    b2.clear     = 1'b0;
    b2.pmem_resp = 1'b0;
    chk({nm, ":done_seen"}, 32'(done), 1);
    chk({nm, ":writebacks"}, wbs, exp_wb);
    chk({nm, ":way_visits"}, visits, 4);
    chk({nm, ":done_pulses"}, dones, 1);
    chk({nm, ":valid_cleared"}, 32'({v2[1][1], v2[1][0], v2[0][1], v2[0][0]}), 0);
    #1 chk({nm, ":after_done"}, 32'({b2.flush_done, b2.cache_stall, b2.pmem_write}), 0);
  endtask

  initial begin
    logic [3:0] hv;
    int w;
    b4.mem_read = 0; b4.mem_write = 0; b4.cpu_stall = 0; b4.clear = 0; b4.flush_req = 0;
    b4.hit_vec = 0; b4.valid_vec = 0; b4.dirty_vec = 0; b4.lru_way = 0; b4.pmem_resp = 0;
    b2.mem_read = 0; b2.mem_write = 0; b2.cpu_stall = 0; b2.clear = 0; b2.flush_req = 0;
    b2.hit_vec = 0; b2.valid_vec = 0; b2.dirty_vec = 0; b2.lru_way = 0; b2.pmem_resp = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    idle4("reset_outputs");
    chk("reset_flush_ctr", 32'({b4.flush_set, b4.flush_way, b2.flush_set, b2.flush_way}), 0);
    rst = 1'b0;
    step();

    // Directed cases
    txn4("rd_hit", 1'b0, 4'b0100, 4'b1111, 4'b0000, 2'd0, 0, 1'b0);
    txn4("wr_miss_dirty", 1'b1, 4'b0000, 4'b1111, 4'b0010, 2'd1, 0, 1'b0);
    txn4("miss_invalid", 1'b0, 4'b0000, 4'b1011, 4'b1111, 2'd0, 0, 1'b0);
    txn4("hit_stall3", 1'b0, 4'b0001, 4'b1111, 4'b0000, 2'd2, 3, 1'b0);
    txn4("wr_hit_stall", 1'b1, 4'b1000, 4'b1111, 4'b0000, 2'd2, 1, 1'b0);
    txn4("verify_clear", 1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 0, 1'b1);

    // Reset while a fill is outstanding
    b4.mem_read  = 1'b1;
    b4.hit_vec   = 4'b0000;
    b4.valid_vec = 4'b1111;
    b4.dirty_vec = 4'b0000;
    b4.lru_way   = 2'd3;
    step();
    step();
    #1 chk("rst_pre_alloc", 32'(b4.pmem_read), 1);
    #1 rst = 1'b1;
    #1 chk("rst_async_drop", 32'({b4.pmem_read, b4.cache_stall}), 0);
    b4.mem_read = 1'b0;
    step();
    rst = 1'b0;
    #1 idle4("rst_idle");
    step();
    txn4("post_rst_miss", 1'b0, 4'b0000, 4'b0111, 4'b0000, 2'd1, 0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 16; t++) begin
      w  = $urandom_range(0, 3);
      hv = ($urandom_range(0, 1) == 1) ? (4'b0001 << w) : 4'b0000;
      txn4("rand", 1'($urandom_range(0, 1)), hv, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b0);
    end

    // Flush: one dirty line at set1/way0, then a random mix
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 2; k++) begin
        v2[s][k] = 1'b1;
        d2[s][k] = 1'b0;
      end
    d2[1][0] = 1'b1;
    run_flush2("flush_one");
    step();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 2; k++) begin
        v2[s][k] = 1'($urandom_range(0, 1));
        d2[s][k] = 1'($urandom_range(0, 1));
      end
    run_flush2("flush_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
